w_pattern_gen: RTL
==================

Name: w_pattern_gen

Overview:
- Serial stimulus source for the w input of the binary and one_hot sequence-detector FSMs; the transmit end of that single-bit w interface.
- Loads a WIDTH-bit pattern, shifts it out MSB-first on w one bit per clk, and repeats it a programmed number of times with optional idle gaps.
- Also emits z_exp, a reference model of the detector output: 1 when the last two transmitted bits are equal. The board top compares z_exp against the detector z.

Parameters:
- WIDTH, 8, pattern length in bits (2..16).
- GAP_CYCLES, 2, idle cycles between repetitions (0..15); w holds at 0 during the gap.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- pattern  input  WIDTH  bits to transmit; captured on the accepted start.
- repeat_n  input  4  number of transmissions; 0 is treated as 1.
- w  output  1  serial bit to the detectors.
- w_valid  output  1  high while w carries a pattern bit (low in gap and idle).
- z_exp  output  1  expected detector z for the current cycle.
- busy  output  1  high from accepted start until DONE is exited.
- done  output  1  one-cycle pulse after the final bit.
- bit_idx  output  $clog2(WIDTH)  index of the bit currently on w.

Behaviour:
- reset low at a clk edge: state IDLE; w=0, w_valid=0, z_exp=0, busy=0, done=0, bit_idx=0; shift register, repeat counter and history cleared. Reset overrides every other input and aborts any transfer.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - start=1 captures pattern into the shift register and max(repeat_n,1) into rep_cnt, clears history_valid, and moves to SHIFT.
  - busy goes high on the edge that accepts start.
- SHIFT:
  - w = shreg[WIDTH-1], w_valid=1.
  - Each cycle: shift left, increment bit_idx.
  - First bit appears on w the cycle after start is accepted (latency 1).
  - After bit WIDTH-1: decrement rep_cnt. If rep_cnt was 1, go to DONE. Otherwise reload the captured pattern and go to GAP, or straight back to SHIFT when GAP_CYCLES=0 (back-to-back, no bubble).
- GAP:
  - w=0, w_valid=0.
  - gap counter counts GAP_CYCLES cycles, then returns to SHIFT with bit_idx=0.
  - history is not updated in GAP, so detection continuity across repetitions depends only on transmitted bits.
- DONE: done=1 for exactly one cycle, busy=1; next state IDLE (busy=0).
- start while busy is ignored and not queued.
- pattern/repeat_n changes after capture have no effect until the next accepted start.
- z_exp is a registered model of the detector:
  - On every cycle with w_valid=1, prev_w<=w and history_valid<=1.
  - z_exp is combinational: w_valid & history_valid & (w==prev_w).
  - So z_exp is 0 on the first bit of a transfer.
  - z_exp is aligned with the detector z of the cycle after w is sampled; the top registers z_exp once before comparison.
- Width rules: bit_idx wraps WIDTH-1 -> 0 only on reload; rep_cnt never underflows.

Decomposition:
- Shared package w_gen_pkg:
  - state enum {IDLE, SHIFT, GAP, DONE} encoded as 2-bit binary;
  - constants REP_W=4 and GAP_W=4.
- One natural sub-module: w_expect_model, holding prev_w, history_valid and the z_exp logic. It is reusable by the binary/one_hot benches as a scoreboard.

Test Plan:
- Reset mid-transfer: pattern=8'hA5, start, then reset low for 1 cycle at bit 3 -> next cycle all outputs 0 and state IDLE; a later start transmits from bit 7 again.
- Single shot: pattern=8'b1100_1110, repeat_n=0 -> w sequence 1,1,0,0,1,1,1,0 on cycles 1-8 after start; z_exp 0,1,0,1,0,1,1,0; done pulses on cycle 9; busy high cycles 0-9.
- Repeat with gap: pattern=8'hF0, repeat_n=2, GAP_CYCLES=2 -> 8 bits, 2 cycles with w_valid=0 and w=0, 8 bits again; z_exp on the first bit of the second pass is 0 (prev=0, w=1).
- Back-to-back: GAP_CYCLES=0, pattern=8'h81, repeat_n=3 -> 24 consecutive valid bits with no bubble; z_exp=1 at each pass boundary (1->1).
- Start ignored while busy: assert start with pattern=8'h00 during a transfer of 8'hFF -> the stream stays all ones; exactly one done pulse.

Source files
------------

// File: rtl/w_gen_pkg.sv
// rtl/w_gen_pkg.sv - shared state encoding and counter widths for the w pattern generator
package w_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int REP_W = 4;
  localparam int GAP_W = 4;

endpackage

// File: rtl/w_pattern_gen_if.sv
// rtl/w_pattern_gen_if.sv - control and serial-stream bundle between a controller and the generator
interface w_pattern_gen_if
  import w_gen_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic                     start;
  logic [WIDTH-1:0]         pattern;
  logic [REP_W-1:0]         repeat_n;
  logic                     w;
  logic                     w_valid;
  logic                     z_exp;
  logic                     busy;
  logic                     done;
  logic [$clog2(WIDTH)-1:0] bit_idx;

  modport master (
    output start, pattern, repeat_n,
    input  w, w_valid, z_exp, busy, done, bit_idx
  );

  modport slave (
    input  start, pattern, repeat_n,
    output w, w_valid, z_exp, busy, done, bit_idx
  );

endinterface

// File: rtl/w_expect_model.sv
// rtl/w_expect_model.sv - reference model of the detector z: last two transmitted bits equal
module w_expect_model (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic w_i,
  input  logic w_valid_i,
  output logic z_exp_o
);

  logic prev_w_q;
  logic history_valid_q;

  // History only advances on transmitted bits, so idle gaps are transparent to detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_w_q        <= 1'b0;
      history_valid_q <= 1'b0;
    end else if (clear_i) begin
      history_valid_q <= 1'b0;
    end else if (w_valid_i) begin
      prev_w_q        <= w_i;
      history_valid_q <= 1'b1;
    end
  end

  assign z_exp_o = w_valid_i & history_valid_q & (w_i == prev_w_q);

endmodule

// File: rtl/w_pattern_gen.sv
// rtl/w_pattern_gen.sv - MSB-first serial pattern source with repeat count and idle gaps
module w_pattern_gen
  import w_gen_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  w_pattern_gen_if.slave  bus
);

  localparam int IDX_W = $clog2(WIDTH);

  state_e            state_q;
  logic [WIDTH-1:0]  shreg_q;
  logic [WIDTH-1:0]  pat_q;
  logic [REP_W-1:0]  rep_cnt_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic [IDX_W-1:0]  bit_idx_q;
  logic              w_valid_q;
  logic              busy_q;
  logic              done_q;

  logic [REP_W-1:0]  rep_init_d;
  logic              last_bit;
  logic              gap_last;
  logic              accept;

  assign rep_init_d = (bus.repeat_n == '0) ? REP_W'(1) : bus.repeat_n;
  assign last_bit   = (bit_idx_q == IDX_W'(WIDTH - 1));
  assign gap_last   = (gap_cnt_q == GAP_W'(GAP_CYCLES - 1));
  assign accept     = (state_q == IDLE) && bus.start;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      pat_q     <= '0;
      rep_cnt_q <= '0;
      gap_cnt_q <= '0;
      bit_idx_q <= '0;
      w_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            shreg_q   <= bus.pattern;
            pat_q     <= bus.pattern;
            rep_cnt_q <= rep_init_d;
            bit_idx_q <= '0;
            w_valid_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            if (rep_cnt_q != '0) rep_cnt_q <= rep_cnt_q - REP_W'(1);
            if (rep_cnt_q <= REP_W'(1)) begin
              w_valid_q <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= DONE;
            end else begin
              shreg_q   <= pat_q;
              bit_idx_q <= '0;
              // With no gap the next pass follows the last bit with no bubble.
              if (GAP_CYCLES == 0) begin
                state_q <= SHIFT;
              end else begin
                w_valid_q <= 1'b0;
                gap_cnt_q <= '0;
                state_q   <= GAP;
              end
            end
          end else begin
            shreg_q   <= shreg_q << 1;
            bit_idx_q <= bit_idx_q + IDX_W'(1);
          end
        end
        GAP: begin
          if (gap_last) begin
            w_valid_q <= 1'b1;
            state_q   <= SHIFT;
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.w       = w_valid_q & shreg_q[WIDTH-1];
  assign bus.w_valid = w_valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bit_idx = bit_idx_q;

  w_expect_model u_expect (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (accept),
    .w_i       (bus.w),
    .w_valid_i (bus.w_valid),
    .z_exp_o   (bus.z_exp)
  );

endmodule
